address_sequencer: RTL and testbench
====================================

# address_sequencer

Parametrised successor to the Z80 address latch/incrementer. Holds an AW-bit address latch and a combinational ±1 incrementer with optional partial-width carry for R-register refresh. Adds a block-transfer sequencer that steps the latch once per accepted memory cycle until a loaded repeat count reaches zero, as used by LDIR/LDDR/CPIR-style instructions. Sits between the internal address bus and the address pins.

## Interface
- AW, 16, address/latch width
- CW, 16, block repeat counter width
- LIMIT_W, 7, carry-chain width when limit is asserted (R-register low bits)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- abus_in  in  AW  internal address bus value
- al_we  in  1  load latch from abus_in
- clr  in  1  force latch to zero (PC/IR clear)
- inc_cy  in  1  incrementer carry-in: 1 = step ±1, 0 = pass-through
- inc_dec  in  1  0 = increment, 1 = decrement
- limit  in  1  confine carry to bits [LIMIT_W-1:0]; upper bits pass unchanged
- apin_sel  in  1  0 = pins show incrementer output, 1 = pins show latch
- inc_oe  in  1  drive latch value onto abus_out
- blk_start  in  1  start block sequence (pulse)
- blk_dec  in  1  block direction, sampled at blk_start
- blk_cnt  in  CW  repeat count, sampled at blk_start
- blk_step  in  1  memory cycle accepted; advance one element
- address  out  AW  address pins
- inc_out  out  AW  incrementer result
- abus_out  out  AW  latch value when inc_oe, else zero
- abus_oe  out  1  equals inc_oe
- address_is_1  out  1  address == 1
- blk_busy  out  1  sequence in progress
- blk_done  out  1  one-cycle completion pulse
- cnt_is_0  out  1  remaining count == 0

## Operation
- Latch update priority per edge: reset > clr > al_we > block step > hold.
- Incrementer: inc_out = latch ± inc_cy, modulo 2^AW (0xFFFF+1 = 0x0000; 0x0000−1 = 0xFFFF). With limit: low LIMIT_W bits wrap modulo 2^LIMIT_W, bits above unchanged (0x807F+1 → 0x8000).
- During RUN, inc_dec is overridden by captured blk_dec and carry forced to 1; limit ignored.
- FSM states IDLE, RUN, DONE.
  - IDLE: blk_start with blk_cnt≠0 → RUN, count ← blk_cnt; with blk_cnt=0 → DONE directly, no step.
  - RUN: blk_step and no al_we/clr → latch ← inc_out, count ← count−1; when count reaches 0 → DONE.
  - DONE: blk_done=1 for one cycle → IDLE.
- blk_start in RUN or DONE ignored. blk_step in IDLE/DONE ignored.
- al_we in RUN: latch loads abus_in; that cycle's step is dropped, count unchanged.
- clr or reset in RUN: latch zeroed, count zeroed, → IDLE, no blk_done.
- blk_busy = (state==RUN).

## Timing
- Reset values: latch 0, count 0, state IDLE, blk_busy 0, blk_done 0, cnt_is_0 1; address = inc_out (0 or 1 per inc_cy) since apin_sel is combinational.
- Latch, count, state: registered, one-cycle latency from al_we/clr/blk_step.
- inc_out, address, abus_out, address_is_1, cnt_is_0: combinational from registers and current controls, zero latency.
- Block of N elements: blk_busy high N cycles minimum (one per blk_step), blk_done the cycle after the last step.

## Configuration
- ADDRESS_SEQUENCER_LIMIT_EN: defined → limit input honoured as above. Undefined → limit ignored, carry always spans full AW; LIMIT_W unused.

## Structure
- address_sequencer_pkg: FSM state enum (IDLE, RUN, DONE), apin_sel encodings.
- Sub-module inc_dec_unit: combinational AW-bit ±carry with optional limit, parametrised by AW and LIMIT_W.

## Test plan
- Load 0x1234, inc_cy=1, apin_sel=0 → address 0x1235; inc_dec=1 → 0x1233; inc_cy=0 → 0x1234.
- Load 0xFFFF, +1 → 0x0000; load 0x0000, −1 → 0xFFFF; address_is_1 high after load 0x0000 with +1.
- Limit enabled: load 0x807F, +1, limit=1 → 0x8000; macro undefined → 0x8080.
- Load 0x4000, blk_start blk_cnt=3 blk_dec=0, blk_step every other cycle → latch 0x4001/0x4002/0x4003, blk_done one cycle after third step, busy 0 thereafter.
- blk_cnt=0 → no step, blk_done next cycle; blk_start while busy → ignored, count unchanged.
- reset mid-block (count 2) → latch 0, IDLE, no blk_done; al_we with blk_step in RUN → latch = abus_in, count unchanged.

Source files
------------

// File: rtl/address_sequencer_pkg.sv
// Shared types for the address sequencer: block-transfer FSM states and
// the address pin source encodings.
package address_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // apin_sel encodings: which value drives the address pins
  localparam logic APIN_INC   = 1'b0;
  localparam logic APIN_LATCH = 1'b1;

endpackage

// File: rtl/address_sequencer_if.sv
// Bus bundle between the control logic (master) and the address sequencer
// (slave): latch/incrementer controls, block-transfer controls and the
// resulting address, bus and status outputs.
interface address_sequencer_if #(
  parameter int AW = 16,
  parameter int CW = 16
);
  logic [AW-1:0] abus_in;
  logic          al_we;
  logic          clr;
  logic          inc_cy;
  logic          inc_dec;
  logic          limit;
  logic          apin_sel;
  logic          inc_oe;
  logic          blk_start;
  logic          blk_dec;
  logic [CW-1:0] blk_cnt;
  logic          blk_step;
  logic [AW-1:0] address;
  logic [AW-1:0] inc_out;
  logic [AW-1:0] abus_out;
  logic          abus_oe;
  logic          address_is_1;
  logic          blk_busy;
  logic          blk_done;
  logic          cnt_is_0;

  modport master (
    output abus_in, al_we, clr, inc_cy, inc_dec, limit, apin_sel, inc_oe,
           blk_start, blk_dec, blk_cnt, blk_step,
    input  address, inc_out, abus_out, abus_oe, address_is_1, blk_busy,
           blk_done, cnt_is_0
  );

  modport slave (
    input  abus_in, al_we, clr, inc_cy, inc_dec, limit, apin_sel, inc_oe,
           blk_start, blk_dec, blk_cnt, blk_step,
    output address, inc_out, abus_out, abus_oe, address_is_1, blk_busy,
           blk_done, cnt_is_0
  );

endinterface

// File: rtl/address_sequencer_inc_dec_unit.sv
// Combinational AW-bit +/-carry unit. With limit set, only the low LIMIT_W
// bits take part in the carry chain (R-register refresh); the upper bits
// pass through unchanged.
module inc_dec_unit #(
  parameter int AW      = 16,
  parameter int LIMIT_W = 7
) (
  input  logic [AW-1:0] a,
  input  logic          carry,
  input  logic          dec,
  input  logic          limit,
  output logic [AW-1:0] y
);

  logic [AW-1:0]      full;
  logic [LIMIT_W-1:0] low;

  // full-width and confined-width results, selected by limit
  always_comb begin
    full = dec ? a - {{(AW-1){1'b0}}, carry} : a + {{(AW-1){1'b0}}, carry};
    low  = dec ? a[LIMIT_W-1:0] - {{(LIMIT_W-1){1'b0}}, carry}
               : a[LIMIT_W-1:0] + {{(LIMIT_W-1){1'b0}}, carry};
    y    = limit ? {a[AW-1:LIMIT_W], low} : full;
  end

endmodule

// File: rtl/address_sequencer.sv
// Address latch with +/-1 incrementer and a block-transfer sequencer that
// steps the latch once per accepted memory cycle until the repeat count
// runs out (LDIR/LDDR/CPIR style).
// Optional feature: define ADDRESS_SEQUENCER_LIMIT_EN to honour the limit
// input (carry confined to the low LIMIT_W bits); otherwise limit is ignored.
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int AW      = 16,
  parameter int CW      = 16,
  parameter int LIMIT_W = 7
) (
  input logic               clk,
  input logic               reset,
  address_sequencer_if.slave bus
);

  state_t        state;
  logic [AW-1:0] latch;
  logic [CW-1:0] count;
  logic          dir;
  logic          busy_q;
  logic          done_q;
  logic          limit_req;
  logic          eff_cy;
  logic          eff_dec;
  logic          eff_lim;
  logic [AW-1:0] inc_val;

`ifdef ADDRESS_SEQUENCER_LIMIT_EN
  assign limit_req = bus.limit;
`else
  logic unused_limit;
  assign unused_limit = bus.limit;
  assign limit_req    = 1'b0;
`endif

  // a running block owns the incrementer: forced +/-1 in the captured direction
  always_comb begin
    eff_cy  = bus.inc_cy;
    eff_dec = bus.inc_dec;
    eff_lim = limit_req;
    if (state == RUN) begin
      eff_cy  = 1'b1;
      eff_dec = dir;
      eff_lim = 1'b0;
    end
  end

  inc_dec_unit #(.AW(AW), .LIMIT_W(LIMIT_W)) u_inc (
    .a     (latch),
    .carry (eff_cy),
    .dec   (eff_dec),
    .limit (eff_lim),
    .y     (inc_val)
  );

  // latch, repeat count and block FSM; priority reset > clr > al_we > step
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      latch  <= '0;
      count  <= '0;
      dir    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.clr) begin
      state  <= IDLE;
      latch  <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.al_we) latch <= bus.abus_in;
      case (state)
        IDLE: begin
          if (bus.blk_start) begin
            dir   <= bus.blk_dec;
            count <= bus.blk_cnt;
            if (bus.blk_cnt != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // a simultaneous latch load wins and the step is dropped
          if (bus.blk_step && !bus.al_we) begin
            latch <= inc_val;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // pin, bus and status outputs, combinational from registers and controls
  always_comb begin
    bus.inc_out      = inc_val;
    bus.address      = (bus.apin_sel == APIN_LATCH) ? latch : inc_val;
    bus.abus_out     = bus.inc_oe ? latch : '0;
    bus.abus_oe      = bus.inc_oe;
    bus.address_is_1 = (bus.address == AW'(1));
    bus.blk_busy     = busy_q;
    bus.blk_done     = done_q;
    bus.cnt_is_0     = (count == '0);
  end

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: directed vector table, a reset-mid-block
// sequence and randomized cycles checked against a behavioural model.
module tb_address_sequencer;

`ifdef ADDRESS_SEQUENCER_LIMIT_EN
  localparam bit          LIMIT_ON = 1'b1;
  localparam logic [15:0] LIM_EXP  = 16'h8000;
`else
  localparam bit          LIMIT_ON = 1'b0;
  localparam logic [15:0] LIM_EXP  = 16'h8080;
`endif

  logic clk;
  logic reset;

  address_sequencer_if #(.AW(16), .CW(16)) bus ();

  address_sequencer #(.AW(16), .CW(16), .LIMIT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] abus;
    logic        we, clr, cy, dec, lim, sel, oe, start, bdec;
    logic [15:0] cnt;
    logic        step;
    logic [15:0] eaddr;
    logic        ebusy, edone, ecnt0;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // behavioural model state
  logic [15:0] m_latch  = 16'h0;
  int          m_left   = 0;
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_dir    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t nv();
    vec_t v;
    v = '{rst: 1'b0, abus: 16'h0, we: 1'b0, clr: 1'b0, cy: 1'b0, dec: 1'b0,
          lim: 1'b0, sel: 1'b1, oe: 1'b1, start: 1'b0, bdec: 1'b0, cnt: 16'h0,
          step: 1'b0, eaddr: 16'h0, ebusy: 1'b0, edone: 1'b0, ecnt0: 1'b1};
    return v;
  endfunction

  task automatic add(input logic [15:0] abus, input logic we, clr, cy, dec, lim, sel,
                     input logic start, bdec, input logic [15:0] cnt, input logic step,
                     input logic [15:0] eaddr, input logic ebusy, edone, ecnt0);
    vec_t v;
    v = nv();
    v.abus = abus; v.we = we; v.clr = clr; v.cy = cy; v.dec = dec; v.lim = lim;
    v.sel = sel; v.start = start; v.bdec = bdec; v.cnt = cnt; v.step = step;
    v.eaddr = eaddr; v.ebusy = ebusy; v.edone = edone; v.ecnt0 = ecnt0;
    tbl.push_back(v);
  endtask

  // address arithmetic straight from the rules: +/-1 modulo 2^16, or
  // modulo 128 on the low 7 bits when the limit applies
  function automatic logic [15:0] m_inc(input logic [15:0] l, input bit cy, dec, lim);
    int d, lo;
    d = cy ? (dec ? -1 : 1) : 0;
    if (lim && LIMIT_ON) begin
      lo = (int'(l) % 128 + d + 128) % 128;
      return 16'((int'(l) / 128) * 128 + lo);
    end
    return 16'((int'(l) + d + 65536) % 65536);
  endfunction

  function automatic logic [15:0] m_inc_now();
    if (m_active) return m_inc(m_latch, 1'b1, m_dir, 1'b0);
    return m_inc(m_latch, bus.inc_cy, bus.inc_dec, bus.limit);
  endfunction

  task automatic model_edge();
    bit          was_active = m_active;
    bit          was_done   = m_done;
    logic [15:0] incv       = m_inc_now();
    if (reset || bus.clr) begin
      m_latch = 16'h0; m_left = 0; m_active = 1'b0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (bus.al_we) m_latch = bus.abus_in;
    else if (was_active && bus.blk_step) begin
      m_latch = incv;
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    if (!was_active && !was_done && bus.blk_start) begin
      m_dir = bus.blk_dec;
      if (bus.blk_cnt != 16'h0) begin
        m_active = 1'b1;
        m_left   = int'(bus.blk_cnt);
      end else m_done = 1'b1;
    end
  endtask

  // mode 0: compare against the vector's expectations; 1: against the model; 2: none
  task automatic run_cycle(input vec_t v, input int mode);
    logic [15:0] mi;
    @(negedge clk);
    reset = v.rst;
    bus.abus_in = v.abus; bus.al_we = v.we; bus.clr = v.clr; bus.inc_cy = v.cy;
    bus.inc_dec = v.dec; bus.limit = v.lim; bus.apin_sel = v.sel; bus.inc_oe = v.oe;
    bus.blk_start = v.start; bus.blk_dec = v.bdec; bus.blk_cnt = v.cnt;
    bus.blk_step = v.step;
    #1;
    if (mode == 0) begin
      chk("vec_address", bus.address, v.eaddr);
      chk("vec_is_1", bus.address_is_1, (v.eaddr == 16'h1));
      chk("vec_busy", bus.blk_busy, v.ebusy);
      chk("vec_done", bus.blk_done, v.edone);
      chk("vec_cnt_is_0", bus.cnt_is_0, v.ecnt0);
    end else if (mode == 1) begin
      mi = m_inc_now();
      chk("mdl_inc_out", bus.inc_out, mi);
      chk("mdl_address", bus.address, v.sel ? m_latch : mi);
      chk("mdl_abus_out", bus.abus_out, v.oe ? m_latch : 16'h0);
      chk("mdl_abus_oe", bus.abus_oe, v.oe);
      chk("mdl_is_1", bus.address_is_1, ((v.sel ? m_latch : mi) == 16'h1));
      chk("mdl_busy", bus.blk_busy, m_active);
      chk("mdl_done", bus.blk_done, m_done);
      chk("mdl_cnt_is_0", bus.cnt_is_0, (m_left == 0));
    end
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    v = nv();
    run_cycle(v, 2);
    run_cycle(v, 2);

    // reset state: latch 0, pins show incrementer (0+1)
    v = nv(); v.rst = 1'b1; v.cy = 1'b1; v.sel = 1'b0; v.eaddr = 16'h0001;
    run_cycle(v, 0);

    //   abus     we clr cy dec lim sel st bd cnt step  eaddr    bsy dn c0
    add(16'h1234, 1, 0, 1, 0, 0, 0, 0, 0, 16'd0, 0, 16'h0001, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'd0, 0, 16'h1235, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 1, 0, 0, 0, 0, 16'd0, 0, 16'h1233, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0, 16'h1234, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 0, 0, 1, 0, 0, 16'd0, 0, 16'h1234, 0, 0, 1);
    add(16'hFFFF, 1, 0, 1, 0, 0, 0, 0, 0, 16'd0, 0, 16'h1235, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'd0, 0, 16'h0000, 0, 0, 1);
    add(16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 1, 0, 0, 0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'd0, 0, 16'h0001, 0, 0, 1);
    add(16'h807F, 1, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h0000, 0, 0, 1);
    add(16'h0000, 0, 0, 1, 0, 1, 0, 0, 0, 16'd0, 0, LIM_EXP,  0, 0, 1);
    add(16'h4000, 1, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h807F, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'd3, 0, 16'h4000, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 1, 1, 0, 0, 0, 16'd0, 0, 16'h4001, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h4000, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4001, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h4001, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4002, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'd9, 1, 16'h4002, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4003, 0, 1, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4003, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'd0, 0, 16'h4003, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4003, 0, 1, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h4003, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 1, 1, 16'd2, 0, 16'h4003, 0, 0, 1);
    add(16'h5555, 1, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h4003, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h5555, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h5555, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h5554, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h5554, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h5553, 0, 1, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h5553, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'd4, 0, 16'h5553, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h5553, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 1, 16'h5554, 1, 0, 0);
    add(16'h0000, 0, 1, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h5555, 1, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h0000, 0, 0, 1);
    add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0, 0, 16'h0000, 0, 0, 1);

    foreach (tbl[i]) run_cycle(tbl[i], 0);

    // reset with two elements still to go: latch cleared, no completion pulse
    v = nv(); v.we = 1'b1; v.abus = 16'h0100;
    run_cycle(v, 1);
    v = nv(); v.start = 1'b1; v.cnt = 16'd4;
    run_cycle(v, 1);
    v = nv(); v.step = 1'b1;
    run_cycle(v, 1);
    run_cycle(v, 1);
    v = nv(); v.rst = 1'b1; v.step = 1'b1;
    run_cycle(v, 1);
    #1;
    chk("rst_mid_latch", bus.address, 16'h0000);
    chk("rst_mid_busy", bus.blk_busy, 1'b0);
    chk("rst_mid_cnt_is_0", bus.cnt_is_0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      v = nv(); v.step = 1'b1;
      run_cycle(v, 1);
      #1;
      chk("rst_mid_no_done", bus.blk_done, 1'b0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      v = nv();
      v.rst   = ($urandom_range(0, 99) == 0);
      v.clr   = ($urandom_range(0, 39) == 0);
      v.we    = ($urandom_range(0, 7) == 0);
      v.abus  = 16'($urandom);
      v.cy    = 1'($urandom);
      v.dec   = 1'($urandom);
      v.lim   = 1'($urandom);
      v.sel   = 1'($urandom);
      v.oe    = 1'($urandom);
      v.start = ($urandom_range(0, 4) == 0);
      v.bdec  = 1'($urandom);
      v.cnt   = 16'($urandom_range(0, 5));
      v.step  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) v.abus = 16'hFFFF;
      if ($urandom_range(0, 15) == 0) v.abus = 16'h007F;
      run_cycle(v, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
